i2c_master_write: RTL and testbench

//  I2C master write engine directly downstream of CLK_DIVIDER. Runs on REF_CLK,

---
 rtl/i2c_master_write.sv | 183 ++++++++++++++++++
 tb/tb_i2c_master_write.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_write.sv
// I2C master write engine: one START / addr+W / N_BYTES data bytes / STOP frame per
// request, clocked by REF_CLK and paced by edges detected on the divider's I2C_CLK level.
module i2c_master_write #(
    parameter int N_BYTES = 2
) (
    input  logic                 REF_CLK,
    input  logic                 RESET,
    input  logic                 I2C_CLK,
    input  logic                 START,
    input  logic [6:0]           ADDR,
    input  logic [8*N_BYTES-1:0] DATA,
    input  logic                 SDA_IN,
    output logic                 SCL,
    output logic                 SDA_OE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ACK_ERR
);
    localparam int DW = 8 * N_BYTES;
    localparam int CW = $clog2(N_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(N_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_A,
        S_ST_B,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          clk_d_q;
    logic          scl_en_q, scl_en_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          ack_bit_q, ack_bit_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [DW-1:0] data_q, data_d;

    logic          rise, fall;
    logic [2:0]    bit_dn;

    assign rise   = I2C_CLK & ~clk_d_q;
    assign fall   = ~I2C_CLK & clk_d_q;
    assign bit_dn = bit_q - 3'd1;

    assign SCL     = scl_en_q ? clk_d_q : 1'b1;
    assign SDA_OE  = sda_oe_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ACK_ERR = ack_err_q;

    // The edge-detect delay keeps tracking I2C_CLK through reset so no false edge
    // is seen on the first cycle after reset is released.
    always_ff @(posedge REF_CLK) begin
        clk_d_q <= I2C_CLK;
    end

    // NOTE: every path of a combinational block assigns each output first (defaults
    // below); otherwise a path that skips an assignment infers a latch.
    always_comb begin
        state_d    = state_q;
        scl_en_d   = scl_en_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        ack_bit_d  = ack_bit_q;
        bit_d      = bit_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                // The DONE cycle is still closing the previous frame.
                if (START && !done_q) begin
                    data_d     = DATA;
                    shift_d    = {ADDR, 1'b0};
                    byte_cnt_d = '0;
                    ack_err_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_ST_A;
                end
            end
            S_ST_A: begin
                if (rise) begin
                    sda_oe_d = 1'b1;
                    state_d  = S_ST_B;
                end
            end
            S_ST_B: begin
                if (fall) begin
                    scl_en_d = 1'b1;
                    sda_oe_d = ~shift_q[7];
                    bit_d    = 3'd7;
                    state_d  = S_BIT;
                end
            end
            S_BIT: begin
                if (fall) begin
                    if (bit_q != 3'd0) begin
                        bit_d    = bit_dn;
                        sda_oe_d = ~shift_q[bit_dn];
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (rise) begin
                    ack_bit_d = SDA_IN;
                end
                if (fall) begin
                    if (ack_bit_q) begin
                        ack_err_d = 1'b1;
                        sda_oe_d  = 1'b1;
                        state_d   = S_STOP;
                    end else if (byte_cnt_q != LAST_BYTE) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        shift_d    = data_q[DW-1 -: 8];
                        data_d     = data_q << 8;
                        sda_oe_d   = ~data_q[DW-1];
                        bit_d      = 3'd7;
                        state_d    = S_BIT;
                    end else begin
                        sda_oe_d = 1'b1;
                        state_d  = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (rise) begin
                    scl_en_d = 1'b0;
                end
                if (fall) begin
                    sda_oe_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge REF_CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            scl_en_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            ack_bit_q  <= 1'b0;
            bit_q      <= 3'd0;
            byte_cnt_q <= '0;
            shift_q    <= 8'h00;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            scl_en_q   <= scl_en_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            ack_bit_q  <= ack_bit_d;
            bit_q      <= bit_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_write.sv
// Directed bench for i2c_master_write: divider model, bus monitor with ACK/NACK slave,
// frame-length, status-handshake and reset checks for N_BYTES=2 and N_BYTES=1.
module tb_i2c_master_write;
    localparam int HALF_DIV = 8;   // I2C_CLK toggles every 8 REF_CLK cycles
    localparam int LEN2     = 472; // (1.5 + 27 + 1) * 16
    localparam int LEN1     = 328; // (1.5 + 18 + 1) * 16
    localparam int LEN_NACK = 184; // 1.5*16 + 9*16 + 16

    logic ref_clk = 1'b0;
    logic reset   = 1'b1;
    logic i2c_clk = 1'b0;
    int   div_cnt = 0;

    logic        start  = 1'b0;
    logic        start1 = 1'b0;
    logic [6:0]  addr   = 7'h50;
    logic [15:0] data   = 16'hA55A;
    logic [7:0]  data1  = 8'h3C;

    logic scl, sda_oe, busy, done, ack_err, sda_bus;
    logic scl1, sda_oe1, busy1, done1, ack_err1;

    logic slave_pull = 1'b0;
    logic nack_addr  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic       prev_scl = 1'b1, prev_sda = 1'b1, reset_d = 1'b1;
    logic       in_frame = 1'b0;
    int         bit_cnt = 0, byte_idx = 0;
    logic [7:0] shreg = 8'h00;
    int         start_cnt = 0, stop_cnt = 0, illegal_cnt = 0, rise_cnt = 0, done_cnt = 0;
    logic [7:0] bytes[$];

    assign sda_bus = ~(sda_oe | slave_pull);

    i2c_master_write #(.N_BYTES(2)) dut (
        .REF_CLK(ref_clk), .RESET(reset), .I2C_CLK(i2c_clk), .START(start),
        .ADDR(addr), .DATA(data), .SDA_IN(sda_bus),
        .SCL(scl), .SDA_OE(sda_oe), .BUSY(busy), .DONE(done), .ACK_ERR(ack_err)
    );

    i2c_master_write #(.N_BYTES(1)) dut1 (
        .REF_CLK(ref_clk), .RESET(reset), .I2C_CLK(i2c_clk), .START(start1),
        .ADDR(addr), .DATA(data1), .SDA_IN(1'b0),
        .SCL(scl1), .SDA_OE(sda_oe1), .BUSY(busy1), .DONE(done1), .ACK_ERR(ack_err1)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) begin
        if (div_cnt == HALF_DIV - 1) begin
            div_cnt <= 0;
            i2c_clk <= ~i2c_clk;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    // Bus monitor and slave: decodes START/STOP and bytes, ACKs unless told to NACK
    // the address, and flags any SDA change coincident with SCL rising.
    always @(negedge ref_clk) begin
        logic scl_now, sda_now;
        scl_now = scl;
        sda_now = sda_bus;
        if (done) done_cnt++;
        if (reset) begin
            in_frame   = 1'b0;
            slave_pull = 1'b0;
            bit_cnt    = 0;
        end else if (!reset_d) begin
            if (scl_now && prev_scl && prev_sda && !sda_now) begin
                start_cnt++;
                in_frame = 1'b1;
                bit_cnt  = 0;
                byte_idx = 0;
            end else if (scl_now && prev_scl && !prev_sda && sda_now) begin
                stop_cnt++;
                in_frame = 1'b0;
            end else if (sda_now != prev_sda && scl_now) begin
                illegal_cnt++;
            end
            if (scl_now && !prev_scl && in_frame) begin
                rise_cnt++;
                if (bit_cnt < 8) begin
                    shreg = {shreg[6:0], sda_now};
                    bit_cnt++;
                    if (bit_cnt == 8) bytes.push_back(shreg);
                end else if (bit_cnt == 8) begin
                    bit_cnt = 9;
                end
            end
            if (!scl_now && prev_scl && in_frame) begin
                if (bit_cnt == 8) begin
                    slave_pull = !(nack_addr && byte_idx == 0);
                    byte_idx++;
                end else if (bit_cnt == 9) begin
                    slave_pull = 1'b0;
                    bit_cnt    = 0;
                end
            end
        end
        prev_scl = scl_now;
        prev_sda = sda_now;
        reset_d  = reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just after I2C_CLK rose, so a START raised now is
    // accepted on the same REF_CLK edge that sees the rise.
    task automatic wait_aligned();
        int guard;
        guard = 0;
        do begin
            @(negedge ref_clk);
            guard++;
        end while (!(i2c_clk && div_cnt == 0) && guard < 64);
        if (guard >= 64) begin
            n_checks++;
            n_errors++;
            $display("FAIL align_timeout: no I2C_CLK rise within %0d cycles", guard);
        end
    endtask

    task automatic wait_done(input bit use1, input int pulse_at, output int cyc);
        cyc = 0;
        while (!(use1 ? done1 : done) && cyc < 2000) begin
            start = (cyc == pulse_at);
            @(negedge ref_clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no DONE within %0d cycles", cyc);
        end
    endtask

    initial begin
        int cyc, base, s0, p0, r0, d0;

        // 1. reset
        repeat (3) @(negedge ref_clk);
        check("rst_scl", scl, 1);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        reset = 1'b0;
        repeat (5) @(negedge ref_clk);

        // 2. full frame, all bytes ACKed
        base = bytes.size(); s0 = start_cnt; p0 = stop_cnt; r0 = rise_cnt; d0 = done_cnt;
        wait_aligned();
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        check("t2_busy_accept", busy, 1);
        wait_done(1'b0, -1, cyc);
        check("t2_len", cyc, LEN2);
        check("t2_busy_at_done", busy, 0);
        check("t2_ack_err", ack_err, 0);
        repeat (20) @(negedge ref_clk);
        check("t2_done_pulses", done_cnt - d0, 1);
        check("t2_starts", start_cnt - s0, 1);
        check("t2_stops", stop_cnt - p0, 1);
        check("t2_scl_rises", rise_cnt - r0, 28);
        check("t2_nbytes", bytes.size() - base, 3);
        check("t2_byte0", bytes[base], 8'hA0);
        check("t2_byte1", bytes[base + 1], 8'hA5);
        check("t2_byte2", bytes[base + 2], 8'h5A);

        // 3. address NACK
        nack_addr = 1'b1;
        base = bytes.size(); s0 = start_cnt; p0 = stop_cnt; r0 = rise_cnt; d0 = done_cnt;
        wait_aligned();
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        wait_done(1'b0, -1, cyc);
        check("t3_len", cyc, LEN_NACK);
        check("t3_ack_err", ack_err, 1);
        repeat (20) @(negedge ref_clk);
        nack_addr = 1'b0;
        check("t3_done_pulses", done_cnt - d0, 1);
        check("t3_stops", stop_cnt - p0, 1);
        check("t3_scl_rises", rise_cnt - r0, 10);
        check("t3_nbytes", bytes.size() - base, 1);
        check("t3_byte0", bytes[base], 8'hA0);
        check("t3_ack_err_held", ack_err, 1);

        // 4. new START clears ACK_ERR; START while BUSY and in the DONE cycle ignored
        base = bytes.size(); s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
        wait_aligned();
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        check("t4_ack_err_cleared", ack_err, 0);
        wait_done(1'b0, 50, cyc);
        check("t4_len", cyc, LEN2);
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        check("t4_start_in_done_cycle", busy, 0);
        repeat (40) @(negedge ref_clk);
        check("t4_busy_idle", busy, 0);
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_starts", start_cnt - s0, 1);
        check("t4_stops", stop_cnt - p0, 1);
        check("t4_nbytes", bytes.size() - base, 3);
        check("t4_byte2", bytes[base + 2], 8'h5A);

        // 5. reset in the middle of the first data byte
        d0 = done_cnt;
        wait_aligned();
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        cyc = 0;
        while (!(byte_idx == 1 && bit_cnt >= 4 && bit_cnt < 8) && cyc < 1000) begin
            @(negedge ref_clk);
            cyc++;
        end
        check("t5_mid_byte_reached", busy, 1);
        reset = 1'b1;
        @(negedge ref_clk);
        check("t5_scl", scl, 1);
        check("t5_sda_oe", sda_oe, 0);
        check("t5_busy", busy, 0);
        reset = 1'b0;
        repeat (600) @(negedge ref_clk);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_ack_err", ack_err, 0);
        check("t5_busy_after", busy, 0);

        // 6. N_BYTES=1 frame length
        wait_aligned();
        start1 = 1'b1;
        @(negedge ref_clk);
        start1 = 1'b0;
        check("t6_busy_accept", busy1, 1);
        wait_done(1'b1, -1, cyc);
        check("t6_len", cyc, LEN1);
        check("t6_busy_at_done", busy1, 0);
        check("t6_ack_err", ack_err1, 0);
        check("t6_scl_idle", scl1, 1);

        check("sda_change_while_scl_high", illegal_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
